// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down event counter with programmable
// modulus, variable step, wrap or saturate mode and registered
// terminal-count and load-error flags.
// Optional feature macro: UPDOWN_COUNTER_OVF_STICKY_EN adds ovf_clr and a
// sticky overflow flag that records any terminal-count crossing.
module updown_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int               STEP_W   = 4,
  parameter bit               SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld,
  input  logic              inc,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
  input  logic              ovf_clr,
  output logic              ovf_sticky,
`endif
  output logic [WIDTH-1:0]  q,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              ld_err,
  output logic              zero
);

  // All limit arithmetic is done one bit wider than the count so that
  // q+s never truncates before it is compared against MAX_VAL.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] MODULUS = MAX_EXT + ONE_EXT;

  // Control inputs are folded to 2-state so an X never reaches the state.
  bit ld_b;
  bit inc_b;
  bit dec_b;

  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   eff_step;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   up_wrap;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH:0]   dn_wrap;
  logic             up_over;
  logic             dn_under;
  logic             step_nz;

  logic [WIDTH-1:0] q_next;
  logic             tc_up_next;
  logic             tc_dn_next;
  logic             ld_err_next;

  assign ld_b  = ld;
  assign inc_b = inc;
  assign dec_b = dec;

  // Clamp the requested step to MAX_VAL and form the candidate results.
  always_comb begin
    step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    eff_step = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    q_ext    = {1'b0, q};
    up_sum   = q_ext + eff_step;
    up_wrap  = up_sum - MODULUS;
    dn_diff  = q_ext - eff_step;
    dn_wrap  = q_ext + (MODULUS - eff_step);
    up_over  = (up_sum > MAX_EXT);
    dn_under = (eff_step > q_ext);
    step_nz  = (eff_step != '0);
  end

  // Next count and flags: load beats counting, conflicting or zero steps hold.
  always_comb begin
    q_next      = q;
    tc_up_next  = 1'b0;
    tc_dn_next  = 1'b0;
    ld_err_next = 1'b0;
    if (ld_b) begin
      if (data_in > MAX_VAL) begin
        q_next      = MAX_VAL;
        ld_err_next = 1'b1;
      end else begin
        q_next = data_in;
      end
    end else if (inc_b && !dec_b && step_nz) begin
      if (up_over) begin
        tc_up_next = 1'b1;
        q_next     = SATURATE ? MAX_VAL : up_wrap[WIDTH-1:0];
      end else begin
        q_next = up_sum[WIDTH-1:0];
      end
    end else if (dec_b && !inc_b && step_nz) begin
      if (dn_under) begin
        tc_dn_next = 1'b1;
        q_next     = SATURATE ? '0 : dn_wrap[WIDTH-1:0];
      end else begin
        q_next = dn_diff[WIDTH-1:0];
      end
    end
  end

  // Count and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= '0;
      tc_up  <= 1'b0;
      tc_dn  <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      q      <= q_next;
      tc_up  <= tc_up_next;
      tc_dn  <= tc_dn_next;
      ld_err <= ld_err_next;
    end
  end

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
  // Sticky overflow rises with the crossing flag; a new crossing beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (tc_up_next || tc_dn_next) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

  assign zero = (q == '0);

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Parametrised successor to the team's 8-bit load/increment counter. Adds:
- generic width and programmable modulus
- up and down counting with a variable step
- wrap or saturate mode
- registered terminal-count flags

Used as the general-purpose event/timer counter in datapath and testbench-reference logic. Single clock domain.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, largest count value; counter range is 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1).
- STEP_W, 4, width of the step input (1..WIDTH).
- SATURATE, 0:
  - 0: wrap modulo MAX_VAL+1.
  - 1: clamp at 0 and MAX_VAL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- data_in  in  WIDTH  load value.
- ld  in  1  load data_in.
- inc  in  1  count up by step.
- dec  in  1  count down by step.
- step  in  STEP_W  step magnitude.
- q  out  WIDTH  registered count.
- tc_up  out  1  registered; upward limit crossed this update.
- tc_dn  out  1  registered; downward limit crossed this update.
- ld_err  out  1  registered; last load was out of range.
- zero  out  1  combinational (q == 0).

Behaviour:
- All state updates on the rising edge of clk. Priority: rst > ld > inc/dec.
- Reset (rst=1 at edge): q=0, tc_up=0, tc_dn=0, ld_err=0.
  - Applies mid-operation regardless of ld/inc/dec.
  - zero=1 in the cycle after reset.
- Load (ld=1):
  - data_in <= MAX_VAL: q=data_in, ld_err=0.
  - data_in > MAX_VAL: q=MAX_VAL, ld_err=1 for one cycle.
  - tc_up=tc_dn=0. inc/dec are ignored.
- Effective step: s = min(step, MAX_VAL). If s==0, the count op is a hold with no flags.
- Count (ld=0):
  - inc=1, dec=0: up by s.
  - inc=0, dec=1: down by s.
  - inc=dec=1 or inc=dec=0: hold q, all flags 0.
- Arithmetic: internal sums are WIDTH+1 bits; no truncation before the limit compare.
- Up, SATURATE=0:
  - If q+s > MAX_VAL: q = q+s-(MAX_VAL+1), tc_up=1.
  - Else q = q+s, tc_up=0.
- Up, SATURATE=1:
  - If q+s > MAX_VAL: q = MAX_VAL, tc_up=1.
  - Else q = q+s.
  - Holding at MAX_VAL with further inc keeps asserting tc_up each cycle.
- Down, SATURATE=0:
  - If s > q: q = q+(MAX_VAL+1)-s, tc_dn=1.
  - Else q = q-s.
- Down, SATURATE=1:
  - If s > q: q = 0, tc_dn=1.
  - Else q = q-s.
- Flags are single-cycle pulses, valid in the same cycle as the q value they describe (1-cycle latency from the inputs). tc_up and tc_dn are never both 1.
- Exact landing on MAX_VAL or 0 is not a crossing: no flag.
- q never exceeds MAX_VAL in any mode.
- No X propagation: ld/inc/dec are sampled as 2-state bits.

Optional Feature:
Macro: UPDOWN_COUNTER_OVF_STICKY_EN
- Defined: adds input ovf_clr (1) and output ovf_sticky (1).
  - ovf_sticky sets on any cycle where tc_up or tc_dn is asserted.
  - It holds until ovf_clr=1 or rst=1. Both clear on the next edge.
  - Simultaneous set and ovf_clr: set wins, so ovf_sticky=1.
  - Reset value is 0.
- Undefined: ports absent, no added logic. All other behaviour is identical.

Test Plan:
1. WIDTH=8, MAX_VAL=9, SATURATE=0: rst=1 for 2 cycles with inc=1 -> q=0, zero=1, no flags. Then release rst, inc=1, step=1 for 10 cycles -> q goes 1..9, then 0 with tc_up=1 only on the 0 cycle.
2. Same config: ld=1, data_in=12 -> q=9, ld_err=1 for one cycle. Next cycle dec=1, step=4 -> q=5, ld_err=0. Then step=7 -> q=8 (5+10-7), tc_dn=1.
3. WIDTH=8, MAX_VAL=255, SATURATE=1: load 250, inc with step=3 -> 253, then 255 with tc_up=1, then 255 with tc_up=1 again. Then dec, step=15 -> 240, no flag.
4. Simultaneous ops: q=5, inc=dec=1 -> q stays 5, no flags. ld=1, inc=1, data_in=7 -> q=7 (load wins). rst=1 with ld=1 -> q=0.
5. Step edges, MAX_VAL=9, STEP_W=4: step=0 with inc -> hold, no flag. step=15 -> clamped to 9, so from q=3: q=2, tc_up=1. Landing exactly on 9 from 4 with step=5 -> tc_up=0.
6. With UPDOWN_COUNTER_OVF_STICKY_EN: force a wrap -> ovf_sticky=1 and stays 1 across 20 plain-count cycles. Pulse ovf_clr -> 0 next cycle. ovf_clr coincident with a wrap -> ovf_sticky stays 1.
